shift_issue: RTL and testbench

SHIFT_ISSUE -- requirements
Module: shift_issue

---
 rtl/shift_issue.sv | 136 +++++++++++++
 tb/tb_shift_issue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// shift_issue: two-stage issue block for MIPS shift instructions.
// Decodes sll/srl/sra/sllv/srlv/srav, registers the shifter operands in
// stage 1 and captures the returned shifter result in stage 2.
// Non-shift instructions are consumed and counted. Shifts writing r0 are
// consumed silently.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     instruction bundle handshake
//   inst, rs_val, rt_val  instruction word and register operands
//   flush                 discard stage 1 and any bundle offered this cycle
//   d, sa, right, arith   registered operands to the external shifter
//   sh                    combinational shifter result
//   out_valid/out_ready   result handshake
//   out_data, out_rd      result value and destination register
//   drop_cnt              saturating count of consumed non-shift bundles
module shift_issue #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             flush,
  output logic [31:0]      d,
  output logic [4:0]       sa,
  output logic             right,
  output logic             arith,
  input  logic [31:0]      sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] drop_cnt
);

  logic       s1_valid;
  logic [4:0] s1_rd;

  logic       is_shift;
  logic       var_form;
  logic       dec_right;
  logic       dec_arith;
  logic [4:0] rd;

  logic       s2_free;
  logic       accept;
  logic       s1_load;
  logic       drop;
  logic       s1_to_s2;

  always_comb begin
    is_shift  = 1'b0;
    var_form  = 1'b0;
    dec_right = 1'b0;
    dec_arith = 1'b0;
    if (inst[31:26] == 6'b000000) begin
      case (inst[5:0])
        6'b000000: is_shift = 1'b1;
        6'b000010: begin is_shift = 1'b1; dec_right = 1'b1; end
        6'b000011: begin is_shift = 1'b1; dec_right = 1'b1; dec_arith = 1'b1; end
        6'b000100: begin is_shift = 1'b1; var_form = 1'b1; end
        6'b000110: begin is_shift = 1'b1; var_form = 1'b1; dec_right = 1'b1; end
        6'b000111: begin is_shift = 1'b1; var_form = 1'b1; dec_right = 1'b1; dec_arith = 1'b1; end
        default:   is_shift = 1'b0;
      endcase
    end
  end

  assign rd       = inst[15:11];
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  // Shifts to r0 are accepted but never enter the pipeline.
  assign s1_load  = accept && is_shift && (rd != 5'd0);
  assign drop     = accept && !is_shift;
  // The S1-to-S2 move does not depend on flush, so an entry already in S1
  // completes even when flush is raised in the same cycle.
  assign s1_to_s2 = s1_valid && s2_free;

  // Stage 1: operands are held whenever not reloaded, keeping sh valid
  // while the result waits for stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d        <= '0;
      sa       <= '0;
      right    <= 1'b0;
      arith    <= 1'b0;
      s1_rd    <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (s1_load) begin
        d     <= rt_val;
        sa    <= var_form ? rs_val[4:0] : inst[10:6];
        right <= dec_right;
        arith <= dec_arith;
        s1_rd <= rd;
      end
      // flush forces in_ready low, so it never coincides with s1_load.
      if (flush)
        s1_valid <= 1'b0;
      else if (s1_load)
        s1_valid <= 1'b1;
      else if (s1_to_s2)
        s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register with valid/ready handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
    end else begin
      if (s1_to_s2) begin
        out_valid <= 1'b1;
        out_data  <= sh;
        out_rd    <= s1_rd;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != '1))
      drop_cnt <= drop_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_shift_issue.sv
module tb_shift_issue;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             flush;
  logic [31:0]      d;
  logic [4:0]       sa;
  logic             right;
  logic             arith;
  logic [31:0]      sh;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_rd;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  shift_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .d(d), .sa(sa), .right(right), .arith(arith), .sh(sh),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .drop_cnt(drop_cnt)
  );

  // Downstream shifter seen by the block.
  always_comb begin
    if (!right)
      sh = d << sa;
    else if (arith)
      sh = 32'($signed(d) >>> sa);
    else
      sh = d >> sa;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: two slots holding finished results plus the operands
  // the block should present for the entry in the first slot.
  bit          m_s1_v, m_s2_v;
  logic [31:0] m_s1_data, m_s2_data, m_s1_d;
  logic [4:0]  m_s1_rd, m_s2_rd, m_s1_sa;
  bit          m_s1_right, m_s1_arith;
  int unsigned m_drop;
  bit          last_acc;
  bit          last_in_ready;
  logic [36:0] got_q[$];

  function automatic void ref_decode(input logic [31:0] i, input logic [31:0] rs,
                                     input logic [31:0] rt, output bit ok,
                                     output logic [31:0] res, output logic [4:0] amt,
                                     output bit r, output bit a);
    logic [63:0] ext;
    ok = 0; r = 0; a = 0; res = '0; amt = i[10:6];
    if (i[31:26] == 6'd0) begin
      case (i[5:0])
        6'd0: ok = 1;
        6'd2: begin ok = 1; r = 1; end
        6'd3: begin ok = 1; r = 1; a = 1; end
        6'd4: begin ok = 1; amt = rs[4:0]; end
        6'd6: begin ok = 1; r = 1; amt = rs[4:0]; end
        6'd7: begin ok = 1; r = 1; a = 1; amt = rs[4:0]; end
        default: ok = 0;
      endcase
    end
    if (ok) begin
      if (!r)
        res = rt << amt;
      else if (!a)
        res = rt >> amt;
      else begin
        ext = {{32{rt[31]}}, rt};
        ext = ext >> amt;
        res = ext[31:0];
      end
    end
  endfunction

  task automatic model_reset();
    m_s1_v = 0; m_s2_v = 0; m_drop = 0;
    m_s1_data = '0; m_s2_data = '0; m_s1_d = '0;
    m_s1_rd = '0; m_s2_rd = '0; m_s1_sa = '0;
    m_s1_right = 0; m_s1_arith = 0;
  endtask

  // One clock cycle with the inputs currently driven; entered and left at
  // 1 time unit after a rising edge.
  task automatic cycle();
    bit          s2free, mir, ok, r, a;
    logic [31:0] res;
    logic [4:0]  amt;
    @(negedge clk);
    s2free = !m_s2_v || out_ready;
    mir    = !flush && (!m_s1_v || s2free);
    last_in_ready = in_ready;
    chk("in_ready", in_ready, mir);
    chk("out_valid", out_valid, m_s2_v);
    if (m_s2_v) begin
      chk("out_data", out_data, m_s2_data);
      chk("out_rd", out_rd, m_s2_rd);
    end
    chk("drop_cnt", 32'(drop_cnt), m_drop);
    if (m_s1_v) begin
      chk("d", d, m_s1_d);
      chk("sa", sa, m_s1_sa);
      chk("right", right, m_s1_right);
      chk("arith", arith, m_s1_arith);
    end
    if (out_valid && out_ready) got_q.push_back({out_rd, out_data});
    @(posedge clk);
    last_acc = in_valid && mir;
    ref_decode(inst, rs_val, rt_val, ok, res, amt, r, a);
    if (m_s1_v && s2free) begin
      m_s2_v = 1; m_s2_data = m_s1_data; m_s2_rd = m_s1_rd;
    end else if (m_s2_v && out_ready) begin
      m_s2_v = 0;
    end
    if (flush) begin
      m_s1_v = 0;
    end else if (last_acc && ok && inst[15:11] != 5'd0) begin
      m_s1_v = 1; m_s1_data = res; m_s1_rd = inst[15:11];
      m_s1_d = rt_val; m_s1_sa = amt; m_s1_right = r; m_s1_arith = a;
    end else if (m_s1_v && s2free) begin
      m_s1_v = 0;
    end
    if (last_acc && !ok && m_drop < 255) m_drop++;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 0;
    for (int unsigned k = 0; k < n; k++) cycle();
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    int unsigned tries;
    in_valid = 1; inst = i; rs_val = rs; rt_val = rt;
    tries = 0;
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < 20);
    chk("offer_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 0;
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_data"}, out_data, 0);
    chk({pfx, "_out_rd"}, out_rd, 0);
    chk({pfx, "_d"}, d, 0);
    chk({pfx, "_sa"}, sa, 0);
    chk({pfx, "_right"}, right, 0);
    chk({pfx, "_arith"}, arith, 0);
    chk({pfx, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  // Asynchronous reset raised between edges; entered and left at edge+1.
  task automatic apply_reset(input string pfx);
    #2 rst = 1;
    #1 chk_zero_outputs(pfx);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    chk({pfx, "_in_ready"}, in_ready, !flush);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [5:0] fn[6];
    int unsigned r;
    logic [4:0] rdv;
    fn[0] = 6'd0; fn[1] = 6'd2; fn[2] = 6'd3; fn[3] = 6'd4; fn[4] = 6'd6; fn[5] = 6'd7;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      rdv = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      return {6'd0, 5'($urandom), 5'($urandom), rdv, 5'($urandom), fn[$urandom_range(0, 5)]};
    end else if (r < 8)
      return $urandom;
    else if (r == 8)
      return 32'd0;
    else
      return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 6'h20};
  endfunction

  initial begin
    rst = 1; in_valid = 0; inst = '0; rs_val = '0; rt_val = '0;
    flush = 0; out_ready = 0;
    model_reset();
    #3 chk_zero_outputs("por");
    @(posedge clk);
    #1 rst = 0;
    chk("por_in_ready", in_ready, 1);
    idle(1);

    // Fixed-amount shifts back to back.
    out_ready = 1;
    got_q.delete();
    offer(32'h00021A00, 32'h0, 32'hff0000ff);
    offer(32'h00021A02, 32'h0, 32'hff0000ff);
    offer(32'h00021A03, 32'h0, 32'hff0000ff);
    idle(4);
    chk("fix_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("fix_sll", got_q[0], {5'd3, 32'h0000ff00});
      chk("fix_srl", got_q[1], {5'd3, 32'h00ff0000});
      chk("fix_sra", got_q[2], {5'd3, 32'hffff0000});
    end

    // Variable arithmetic shift uses only rs[4:0].
    got_q.delete();
    offer(32'h00221807, 32'h00000028, 32'hff0000ff);
    chk("srav_d", d, 32'hff0000ff);
    chk("srav_sa", sa, 8);
    chk("srav_right", right, 1);
    chk("srav_arith", arith, 1);
    idle(3);
    chk("srav_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("srav_res", got_q[0], {5'd3, 32'hffff0000});

    // Backpressure: three shifts offered while the sink stalls.
    begin
      logic [31:0] bp[3];
      int unsigned idx;
      bp[0] = 32'h00022040; bp[1] = 32'h00022902; bp[2] = 32'h00023403;
      got_q.delete();
      idx = 0;
      rt_val = 32'hff0000ff; rs_val = 32'h0;
      for (int unsigned c = 0; c < 12; c++) begin
        out_ready = (c >= 3);
        if (idx < 3) begin in_valid = 1; inst = bp[idx]; end
        else in_valid = 0;
        cycle();
        if (c == 2) chk("bp_in_ready", last_in_ready, 0);
        if (last_acc) idx++;
      end
      in_valid = 0;
      chk("bp_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
        chk("bp_res0", got_q[0], {5'd4, 32'hfe0001fe});
        chk("bp_res1", got_q[1], {5'd5, 32'h0ff0000f});
        chk("bp_res2", got_q[2], {5'd6, 32'hffffff00});
      end
    end

    // Flush with S1 full and S2 empty: S1 still completes, new bundle refused.
    out_ready = 1;
    got_q.delete();
    offer(32'h00023900, 32'h0, 32'hff0000ff);
    flush = 1; in_valid = 1; inst = 32'h00021A00;
    cycle();
    chk("flush_in_ready", last_in_ready, 0);
    chk("flush_acc", {31'd0, last_acc}, 0);
    flush = 0; in_valid = 0;
    idle(3);
    chk("flush_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("flush_res", got_q[0], {5'd7, 32'hf0000ff0});

    // Reset while both stages hold results.
    out_ready = 0;
    offer(32'h00021A00, 32'h0, 32'hff0000ff);
    offer(32'h00021A02, 32'h0, 32'hff0000ff);
    chk("prerst_full", {30'd0, m_s1_v, m_s2_v}, 3);
    apply_reset("mid");
    out_ready = 1;
    got_q.delete();
    idle(5);
    chk("mid_no_stale", got_q.size(), 0);

    // Randomized traffic.
    for (int unsigned c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      inst      = gen_inst();
      rs_val    = $urandom;
      rt_val    = $urandom;
      cycle();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    idle(3);

    // Drop counting and saturation.
    apply_reset("drop");
    got_q.delete();
    offer(32'h00221820, 32'h0, 32'h0);
    offer(32'h00000000, 32'h0, 32'h0);
    idle(3);
    chk("drop_one", 32'(drop_cnt), 1);
    chk("drop_no_out", got_q.size(), 0);
    for (int unsigned k = 0; k < 300; k++)
      offer({6'($urandom_range(1, 63)), 26'($urandom)}, $urandom, $urandom);
    idle(2);
    chk("drop_sat", 32'(drop_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
